// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 7;
    localparam int NUM_REGS   = 1 << ADDR_W;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    // Origin of the write currently presented on the register-file port.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_EXT  = 2'd2
    } src_e;

    // Anti-starvation controller states.
    typedef enum logic {
        ST_NORM  = 1'b0,
        ST_FORCE = 1'b1
    } arb_state_e;

    // One buffered external-ALU result.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ext_entry_t;

    // One-hot mask selecting a single register index.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// Small in-order buffer for external-ALU results waiting for the RF write port.
module rf_arb_fifo
    import rf_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  ext_entry_t       din,
    output ext_entry_t       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    ext_entry_t       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_r == CNT_W'(0));
    assign count   = count_r;
    assign head    = mem_r[rd_ptr_r];
    // Overflow/underflow requests are ignored so stored entries are never lost.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage, pointers and occupancy; simultaneous push/pop keeps count steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter: pipeline writeback vs. external-ALU results,
// with a per-register pending-result scoreboard.
// Optional anti-starvation of buffered ext results: define RF_WR_ARB_STARVE_EN.
module rf_wr_arb
    import rf_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_we,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                ext_vld,
    input  logic [ADDR_W-1:0]   ext_addr,
    input  logic [DATA_W-1:0]   ext_data,
    output logic                ext_rdy,
    input  logic                ext_issue,
    input  logic [ADDR_W-1:0]   ext_issue_addr,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_w_addr,
    output logic [DATA_W-1:0]   rf_w_data,
    output logic [NUM_REGS-1:0] busy,
    output logic                wb_stall
);

    ext_entry_t          ext_in_s;
    ext_entry_t          fifo_head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CNT_W-1:0]    fifo_count_s;
    logic                fifo_push_s;
    logic                fifo_pop_s;
    logic                grant_wb_s;
    logic                grant_byp_s;
    src_e                src_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;
    src_e                rf_src_r;
    logic [NUM_REGS-1:0] busy_next_s;

    assign ext_in_s = '{addr: ext_addr, data: ext_data};
    assign ext_rdy  = (fifo_count_s < CNT_W'(FIFO_DEPTH));

    rf_arb_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (ext_in_s),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Fixed-priority grant: pipeline, then oldest buffered result, then bypass.
    // Bypass is only possible with an empty buffer, so arrival order is kept.
    always_comb begin
        grant_wb_s  = 1'b0;
        grant_byp_s = 1'b0;
        fifo_pop_s  = 1'b0;
        src_s       = SRC_NONE;
        sel_addr_s  = '0;
        sel_data_s  = '0;
        if (wb_we && !wb_stall) begin
            grant_wb_s = 1'b1;
            src_s      = SRC_WB;
            sel_addr_s = wb_addr;
            sel_data_s = wb_data;
        end else if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            src_s      = SRC_EXT;
            sel_addr_s = fifo_head_s.addr;
            sel_data_s = fifo_head_s.data;
        end else if (ext_vld) begin
            grant_byp_s = 1'b1;
            src_s       = SRC_EXT;
            sel_addr_s  = ext_addr;
            sel_data_s  = ext_data;
        end else begin
            src_s = SRC_NONE;
        end
        fifo_push_s = ext_vld && !fifo_full_s && !grant_byp_s;
    end

    // Registered RF write port plus the source tag used for scoreboard clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_w_addr <= '0;
            rf_w_data <= '0;
            rf_src_r  <= SRC_NONE;
        end else begin
            rf_we     <= (src_s != SRC_NONE);
            rf_w_addr <= sel_addr_s;
            rf_w_data <= sel_data_s;
            rf_src_r  <= src_s;
        end
    end

    // Scoreboard update: ext write on the port clears, a new issue sets and wins.
    always_comb begin
        busy_next_s = busy;
        if (rf_we && (rf_src_r == SRC_EXT)) begin
            busy_next_s = busy_next_s & ~reg_mask(rf_w_addr);
        end else begin
            busy_next_s = busy_next_s;
        end
        if (ext_issue) begin
            busy_next_s = busy_next_s | reg_mask(ext_issue_addr);
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next_s;
        end
    end

`ifdef RF_WR_ARB_STARVE_EN
    arb_state_e          state_r;
    arb_state_e          state_next_s;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic [STARVE_W-1:0] starve_cnt_next_s;

    // The stall flag is the FORCE state bit itself, so it comes straight from a flop.
    assign wb_stall = (state_r == ST_FORCE);

    // Starvation tracking: count pipeline wins while results wait; a pop clears it.
    always_comb begin
        state_next_s      = ST_NORM;
        starve_cnt_next_s = starve_cnt_r;
        case (state_r)
            ST_NORM: begin
                if ((starve_cnt_r == STARVE_W'(STARVE_MAX)) && !fifo_empty_s) begin
                    state_next_s = ST_FORCE;
                end else begin
                    state_next_s = ST_NORM;
                end
            end
            ST_FORCE: state_next_s = ST_NORM;
            default:  state_next_s = ST_NORM;
        endcase
        if (fifo_pop_s) begin
            starve_cnt_next_s = '0;
        end else if (!fifo_empty_s && grant_wb_s) begin
            starve_cnt_next_s = starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_cnt_next_s = starve_cnt_r;
        end
    end

    // Anti-starvation state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_NORM;
            starve_cnt_r <= '0;
        end else begin
            state_r      <= state_next_s;
            starve_cnt_r <= starve_cnt_next_s;
        end
    end
`else
    assign wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arb.sv
// Scoreboard bench for rf_wr_arb: stimulus pushes expected RF writes, a monitor
// pops and compares whenever rf_we is seen.
module tb_rf_wr_arb;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ext_vld;
    logic [3:0]  ext_addr;
    logic [31:0] ext_data;
    logic        ext_rdy;
    logic        ext_issue;
    logic [3:0]  ext_issue_addr;
    logic        rf_we;
    logic [3:0]  rf_w_addr;
    logic [31:0] rf_w_data;
    logic [15:0] busy;
    logic        wb_stall;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total;
    int  bad;

    rf_wr_arb dut (
        .clk            (clk),
        .rst            (rst),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .ext_vld        (ext_vld),
        .ext_addr       (ext_addr),
        .ext_data       (ext_data),
        .ext_rdy        (ext_rdy),
        .ext_issue      (ext_issue),
        .ext_issue_addr (ext_issue_addr),
        .rf_we          (rf_we),
        .rf_w_addr      (rf_w_addr),
        .rf_w_data      (rf_w_data),
        .busy           (busy),
        .wb_stall       (wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    // Monitor: every RF write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                         rf_w_addr, rf_w_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_w_addr), 32'(mon_e.a));
                chk("wr_data", rf_w_data, mon_e.d);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        wb_we = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
        ext_vld = 1'b0; ext_addr = 4'd0; ext_data = 32'd0;
        ext_issue = 1'b0; ext_issue_addr = 4'd0;
        step();
        step();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_addr", 32'(rf_w_addr), 32'd0);
        chk("rst_rf_data", rf_w_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ext_rdy", 32'(ext_rdy), 32'd1);
        chk("rst_wb_stall", 32'(wb_stall), 32'd0);
        rst = 1'b0;

        // Pipeline write appears one cycle later.
        wb_we = 1'b1; wb_addr = 4'd3; wb_data = 32'h1234;
        expect_wr(4'd3, 32'h1234);
        step();
        wb_we = 1'b0;
        chk("wb_lat_we", 32'(rf_we), 32'd1);
        chk("wb_lat_addr", 32'(rf_w_addr), 32'd3);

        // Ext bypass with idle pipeline.
        ext_vld = 1'b1; ext_addr = 4'd5; ext_data = 32'hA5A5A5A5;
        chk("byp_rdy_before", 32'(ext_rdy), 32'd1);
        expect_wr(4'd5, 32'hA5A5A5A5);
        step();
        ext_vld = 1'b0;
        chk("byp_rdy_after", 32'(ext_rdy), 32'd1);
        step();

        // Buffering while the pipeline owns the port, then ordered drain.
        wb_we = 1'b1; wb_addr = 4'd0; wb_data = 32'h100;
        ext_vld = 1'b1; ext_addr = 4'd1; ext_data = 32'h11;
        expect_wr(4'd0, 32'h100);
        step();
        ext_addr = 4'd2; ext_data = 32'h22; wb_data = 32'h101;
        chk("fill_rdy_cnt1", 32'(ext_rdy), 32'd1);
        expect_wr(4'd0, 32'h101);
        step();
        ext_addr = 4'd3; ext_data = 32'h33; wb_data = 32'h102;
        chk("fill_rdy_full", 32'(ext_rdy), 32'd0);
        expect_wr(4'd0, 32'h102);
        step();
        chk("full_hold_rdy", 32'(ext_rdy), 32'd0);
        wb_we = 1'b0;
        expect_wr(4'd1, 32'h11);
        step();
        chk("drain_rdy", 32'(ext_rdy), 32'd1);
        expect_wr(4'd2, 32'h22);
        step();
        ext_vld = 1'b0;
        expect_wr(4'd3, 32'h33);
        step();
        chk("drain_done_rdy", 32'(ext_rdy), 32'd1);
        step();

        // Scoreboard set / clear / set-wins.
        ext_issue = 1'b1; ext_issue_addr = 4'd7;
        step();
        ext_issue = 1'b0;
        chk("busy_set", 32'(busy), 32'h80);
        ext_vld = 1'b1; ext_addr = 4'd7; ext_data = 32'h77;
        expect_wr(4'd7, 32'h77);
        step();
        ext_vld = 1'b0;
        chk("busy_during_wr", 32'(busy), 32'h80);
        step();
        chk("busy_clear", 32'(busy), 32'h0);
        ext_issue = 1'b1;
        step();
        ext_issue = 1'b0;
        wb_we = 1'b1; wb_addr = 4'd7; wb_data = 32'h99;
        expect_wr(4'd7, 32'h99);
        step();
        wb_we = 1'b0;
        step();
        chk("busy_wb_keep", 32'(busy), 32'h80);
        ext_vld = 1'b1; ext_addr = 4'd7; ext_data = 32'h78;
        expect_wr(4'd7, 32'h78);
        step();
        ext_vld = 1'b0;
        ext_issue = 1'b1; ext_issue_addr = 4'd7;
        step();
        ext_issue = 1'b0;
        chk("busy_set_wins", 32'(busy), 32'h80);

        // Pipeline held busy while one result waits.
        wb_we = 1'b1; wb_addr = 4'd9;
        ext_vld = 1'b1; ext_addr = 4'd4; ext_data = 32'h44;
        for (int i = 0; i < 12; i++) begin
            wb_data = 32'h200 + 32'(i);
`ifdef RF_WR_ARB_STARVE_EN
            chk("stall_flag", 32'(wb_stall), (i == 9) ? 32'd1 : 32'd0);
            if (i == 9) expect_wr(4'd4, 32'h44);
            else        expect_wr(4'd9, 32'h200 + 32'(i));
`else
            chk("no_stall", 32'(wb_stall), 32'd0);
            expect_wr(4'd9, 32'h200 + 32'(i));
`endif
            step();
            ext_vld = 1'b0;
        end
        wb_we = 1'b0;
`ifndef RF_WR_ARB_STARVE_EN
        expect_wr(4'd4, 32'h44);
`endif
        step();
        step();

        // Reset in the middle of operation with a full buffer.
        wb_we = 1'b1; wb_addr = 4'd8; wb_data = 32'h300;
        ext_vld = 1'b1; ext_addr = 4'hA; ext_data = 32'hAA;
        ext_issue = 1'b1; ext_issue_addr = 4'd4;
        expect_wr(4'd8, 32'h300);
        step();
        ext_addr = 4'hB; ext_data = 32'hBB; ext_issue_addr = 4'd5; wb_data = 32'h301;
        expect_wr(4'd8, 32'h301);
        step();
        ext_vld = 1'b0; ext_issue_addr = 4'd6; wb_data = 32'h302;
        expect_wr(4'd8, 32'h302);
        step();
        ext_issue_addr = 4'd7; wb_data = 32'h303;
        expect_wr(4'd8, 32'h303);
        step();
        ext_issue = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'hF0);
        chk("pre_rst_rdy", 32'(ext_rdy), 32'd0);
        wb_we = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_rf_we", 32'(rf_we), 32'd0);
        chk("arst_addr", 32'(rf_w_addr), 32'd0);
        chk("arst_data", rf_w_data, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rdy", 32'(ext_rdy), 32'd1);
        chk("arst_stall", 32'(wb_stall), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("post_rst_rdy", 32'(ext_rdy), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        wb_we = 1'b1; wb_addr = 4'hC; wb_data = 32'hC0DE;
        expect_wr(4'hC, 32'hC0DE);
        step();
        wb_we = 1'b0;
        chk("post_rst_grant", 32'(rf_we), 32'd1);
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
